// File: rtl/rename_pkg.sv
// rename_pkg: shared constants, payload layout and tag-width helper for the rename stage
package rename_pkg;
    localparam int ARCH_REGS = 32;
    localparam int PAYLOAD_W = 101;
    localparam int PC_LSB = 0;
    localparam int PC_W = 32;
    localparam int OPCODE_LSB = 32;
    localparam int OPCODE_W = 7;
    localparam int FUNCT3_LSB = 39;
    localparam int FUNCT3_W = 3;
    localparam int FUNCT7_LSB = 42;
    localparam int FUNCT7_W = 7;
    localparam int IMM_LSB = 49;
    localparam int IMM_W = 32;
    localparam int LWSW_LSB = 81;
    localparam int LWSW_W = 2;
    localparam int MEMREAD_BIT = 83;
    localparam int MEMWRITE_BIT = 84;
    localparam int MEMTOREG_BIT = 85;
    localparam int HASIMM_BIT = 86;
    localparam int STORESIZE_BIT = 87;
    localparam int RSVD_LSB = 88;
    localparam int RSVD_W = PAYLOAD_W - RSVD_LSB;

    function automatic int tag_width(input int phys_regs);
        return $clog2(phys_regs);
    endfunction
endpackage

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical tags with count and sticky overflow flag
module rename_free_list
    import rename_pkg::*;
#(
    parameter int PHYS_REGS = 64,
    parameter int PTAG_W = tag_width(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop_i,
    input  logic              push_i,
    input  logic [PTAG_W-1:0] push_tag_i,
    output logic [PTAG_W-1:0] head_o,
    output logic [PTAG_W:0]   count_o,
    output logic              overflow_o
);
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [PTAG_W:0]   count_q, count_d;
    logic              ovf_q, full, do_push;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full list is only legal when a pop frees the slot that same edge
    assign full       = count_q == (PTAG_W+1)'(DEPTH);
    assign do_push    = push_i && (!full || pop_i);
    assign count_d    = count_q + (PTAG_W+1)'(do_push) - (PTAG_W+1)'(pop_i);
    assign head_o     = mem_q[head_q];
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PTAG_W'(ARCH_REGS + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (PTAG_W+1)'(DEPTH);
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) mem_q[tail_q] <= push_tag_i;
            if (do_push) tail_q <= wrap_inc(tail_q);
            if (pop_i) head_q <= wrap_inc(head_q);
            count_q <= count_d;
            ovf_q   <= ovf_q | (push_i && !do_push);
        end
    end
endmodule

// File: rtl/rename_stage.sv
// rename_stage: maps architectural to physical registers via a RAT and free list,
// presenting one renamed instruction per cycle through a valid/ready output register
module rename_stage #(
    parameter int PHYS_REGS = 64,
    parameter int PTAG_W = rename_pkg::tag_width(PHYS_REGS),
    parameter int PAYLOAD_W = rename_pkg::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_src1,
    input  logic [4:0]           in_src2,
    input  logic [4:0]           in_dest,
    input  logic                 in_regwrite,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PTAG_W-1:0]    out_psrc1,
    output logic [PTAG_W-1:0]    out_psrc2,
    output logic [PTAG_W-1:0]    out_pdest,
    output logic [PTAG_W-1:0]    out_old_pdest,
    output logic                 out_has_dest,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic                 commit_valid,
    input  logic                 commit_has_dest,
    input  logic [PTAG_W-1:0]    commit_old_pdest,
    output logic [PTAG_W:0]      free_count,
    output logic                 fl_overflow
);
    import rename_pkg::ARCH_REGS;

    logic [PTAG_W-1:0]    rat_q [ARCH_REGS];
    logic [PTAG_W-1:0]    fl_head;
    logic                 need_alloc, accept, pop, push;
    logic                 valid_q, has_dest_q;
    logic [PTAG_W-1:0]    psrc1_q, psrc2_q, pdest_q, old_pdest_q;
    logic [PAYLOAD_W-1:0] payload_q;

    // Readiness uses the registered free count, so a tag freed this cycle is usable next cycle
    assign need_alloc = in_regwrite && (in_dest != 5'd0);
    assign in_ready   = (!valid_q || out_ready) && (!need_alloc || free_count != '0);
    assign accept     = in_valid && in_ready;
    assign pop        = accept && need_alloc;
    assign push       = commit_valid && commit_has_dest && (commit_old_pdest != '0);

    rename_free_list #(
        .PHYS_REGS (PHYS_REGS),
        .PTAG_W    (PTAG_W)
    ) u_free_list (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (pop),
        .push_i     (push),
        .push_tag_i (commit_old_pdest),
        .head_o     (fl_head),
        .count_o    (free_count),
        .overflow_o (fl_overflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rat_q[i] <= PTAG_W'(i);
            valid_q     <= 1'b0;
            psrc1_q     <= '0;
            psrc2_q     <= '0;
            pdest_q     <= '0;
            old_pdest_q <= '0;
            has_dest_q  <= 1'b0;
            payload_q   <= '0;
        end else begin
            if (pop) rat_q[in_dest] <= fl_head;
            if (accept) begin
                valid_q     <= 1'b1;
                psrc1_q     <= rat_q[in_src1];
                psrc2_q     <= rat_q[in_src2];
                pdest_q     <= need_alloc ? fl_head : '0;
                old_pdest_q <= rat_q[in_dest];
                has_dest_q  <= need_alloc;
                payload_q   <= in_payload;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_psrc1     = psrc1_q;
    assign out_psrc2     = psrc2_q;
    assign out_pdest     = pdest_q;
    assign out_old_pdest = old_pdest_q;
    assign out_has_dest  = has_dest_q;
    assign out_payload   = payload_q;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed self-checking bench for rename_stage
module tb_rename_stage;
    localparam int PT = 6;
    localparam int PW = 101;
    localparam logic [PW-1:0] P1 = 101'h1_0123_4567_89AB_CDEF_0123_4567;
    localparam logic [PW-1:0] P2 = 101'h0_FEDC_BA98_7654_3210_FEDC_BA98;
    localparam logic [PW-1:0] P3 = 101'h1_5555_AAAA_5555_AAAA_5555_AAAA;
    localparam logic [PW-1:0] P4 = 101'h0_1111_2222_3333_4444_5555_6666;
    localparam logic [PW-1:0] P5 = 101'h1_7777_8888_9999_AAAA_BBBB_CCCC;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_regwrite;
    logic [4:0]    in_src1, in_src2, in_dest;
    logic [PW-1:0] in_payload, out_payload;
    logic          out_valid, out_ready, out_has_dest;
    logic [PT-1:0] out_psrc1, out_psrc2, out_pdest, out_old_pdest;
    logic          commit_valid, commit_has_dest;
    logic [PT-1:0] commit_old_pdest;
    logic [PT:0]   free_count;
    logic          fl_overflow;
    int            pass_cnt = 0;
    int            total_cnt = 0;

    always #5 clk = ~clk;

    rename_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_src1          (in_src1),
        .in_src2          (in_src2),
        .in_dest          (in_dest),
        .in_regwrite      (in_regwrite),
        .in_payload       (in_payload),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_psrc1        (out_psrc1),
        .out_psrc2        (out_psrc2),
        .out_pdest        (out_pdest),
        .out_old_pdest    (out_old_pdest),
        .out_has_dest     (out_has_dest),
        .out_payload      (out_payload),
        .commit_valid     (commit_valid),
        .commit_has_dest  (commit_has_dest),
        .commit_old_pdest (commit_old_pdest),
        .free_count       (free_count),
        .fl_overflow      (fl_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic rw, input logic [PW-1:0] pl);
        in_valid = v; in_src1 = s1; in_src2 = s2; in_dest = d; in_regwrite = rw; in_payload = pl;
    endtask

    task automatic commit(input logic v, input logic [PT-1:0] tag);
        commit_valid = v; commit_has_dest = v; commit_old_pdest = tag;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, '0);
        commit(0, '0);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0d expected 0", out_valid); else pass_cnt++;
        total_cnt++; if (free_count !== 7'd32) $display("FAIL reset_free: got %0d expected 32", free_count); else pass_cnt++;
        total_cnt++; if (fl_overflow !== 1'b0) $display("FAIL reset_ovf: got %0d expected 0", fl_overflow); else pass_cnt++;
        total_cnt++; if (out_pdest !== 6'd0 || out_has_dest !== 1'b0 || out_payload !== '0) $display("FAIL reset_data: got pdest %0d has %0d expected 0 0", out_pdest, out_has_dest); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %0d expected 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_rename_dep();
        drive(1, 1, 2, 5, 1, P1);
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL add_ready: got %0d expected 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %0d expected 1", out_valid); else pass_cnt++;
        total_cnt++; if (out_psrc1 !== 6'd1 || out_psrc2 !== 6'd2) $display("FAIL add_psrc: got %0d %0d expected 1 2", out_psrc1, out_psrc2); else pass_cnt++;
        total_cnt++; if (out_pdest !== 6'd32 || out_old_pdest !== 6'd5) $display("FAIL add_pdest: got %0d old %0d expected 32 old 5", out_pdest, out_old_pdest); else pass_cnt++;
        total_cnt++; if (out_has_dest !== 1'b1 || free_count !== 7'd31) $display("FAIL add_alloc: got has %0d free %0d expected 1 31", out_has_dest, free_count); else pass_cnt++;
        total_cnt++; if (out_payload !== P1) $display("FAIL add_payload: got %h expected %h", out_payload, P1); else pass_cnt++;
        drive(1, 5, 5, 6, 1, P2);
        tick();
        total_cnt++; if (out_psrc1 !== 6'd32 || out_psrc2 !== 6'd32) $display("FAIL sub_psrc: got %0d %0d expected 32 32", out_psrc1, out_psrc2); else pass_cnt++;
        total_cnt++; if (out_pdest !== 6'd33 || out_old_pdest !== 6'd6) $display("FAIL sub_pdest: got %0d old %0d expected 33 old 6", out_pdest, out_old_pdest); else pass_cnt++;
        total_cnt++; if (free_count !== 7'd30 || out_payload !== P2) $display("FAIL sub_free: got %0d expected 30", free_count); else pass_cnt++;
        drive(0, 0, 0, 0, 0, '0);
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %0d expected 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_no_alloc();
        drive(1, 5, 6, 0, 1, P3);
        tick();
        total_cnt++; if (out_pdest !== 6'd0 || out_has_dest !== 1'b0 || out_old_pdest !== 6'd0) $display("FAIL x0_dest: got pdest %0d has %0d old %0d expected 0 0 0", out_pdest, out_has_dest, out_old_pdest); else pass_cnt++;
        total_cnt++; if (out_psrc1 !== 6'd32 || out_psrc2 !== 6'd33 || free_count !== 7'd30) $display("FAIL x0_src: got %0d %0d free %0d expected 32 33 free 30", out_psrc1, out_psrc2, free_count); else pass_cnt++;
        drive(1, 5, 6, 7, 0, P3);
        tick();
        total_cnt++; if (out_valid !== 1'b1 || out_pdest !== 6'd0 || out_has_dest !== 1'b0) $display("FAIL store_dest: got valid %0d pdest %0d has %0d expected 1 0 0", out_valid, out_pdest, out_has_dest); else pass_cnt++;
        total_cnt++; if (out_old_pdest !== 6'd7 || free_count !== 7'd30) $display("FAIL store_free: got old %0d free %0d expected 7 30", out_old_pdest, free_count); else pass_cnt++;
        drive(0, 0, 0, 0, 0, '0);
        tick();
    endtask

    task automatic test_stall();
        drive(1, 6, 0, 7, 1, P4);
        tick();
        total_cnt++; if (out_pdest !== 6'd34 || out_old_pdest !== 6'd7 || out_psrc1 !== 6'd33 || out_psrc2 !== 6'd0) $display("FAIL pre_stall: got pdest %0d old %0d src %0d %0d expected 34 7 33 0", out_pdest, out_old_pdest, out_psrc1, out_psrc2); else pass_cnt++;
        out_ready = 1'b0;
        drive(1, 7, 5, 8, 1, P5);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_ready: got %0d expected 0", in_ready); else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total_cnt++; if (out_valid !== 1'b1 || out_pdest !== 6'd34 || out_payload !== P4) $display("FAIL stall_hold%0d: got valid %0d pdest %0d expected 1 34", c, out_valid, out_pdest); else pass_cnt++;
            total_cnt++; if (free_count !== 7'd29 || in_ready !== 1'b0) $display("FAIL stall_free%0d: got free %0d ready %0d expected 29 0", c, free_count, in_ready); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL release_ready: got %0d expected 1", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_psrc1 !== 6'd34 || out_psrc2 !== 6'd32) $display("FAIL release_src: got %0d %0d expected 34 32", out_psrc1, out_psrc2); else pass_cnt++;
        total_cnt++; if (out_pdest !== 6'd35 || out_old_pdest !== 6'd8 || free_count !== 7'd28 || out_payload !== P5) $display("FAIL release_dest: got pdest %0d old %0d free %0d expected 35 8 28", out_pdest, out_old_pdest, free_count); else pass_cnt++;
        drive(0, 0, 0, 0, 0, '0);
        tick();
    endtask

    task automatic test_exhaust();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 5'((i % 31) + 1), 1, PW'(i));
            tick();
            total_cnt++; if (out_pdest !== PT'(32 + i)) $display("FAIL exh_pdest%0d: got %0d expected %0d", i, out_pdest, 32 + i); else pass_cnt++;
        end
        drive(1, 0, 0, 3, 1, P1);
        #1;
        total_cnt++; if (free_count !== 7'd0 || in_ready !== 1'b0) $display("FAIL exh_empty: got free %0d ready %0d expected 0 0", free_count, in_ready); else pass_cnt++;
        commit(1, 6'd5);
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL exh_same_cycle: got %0d expected 0", in_ready); else pass_cnt++;
        tick();
        commit(0, '0);
        total_cnt++; if (free_count !== 7'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL exh_freed: got free %0d ready %0d valid %0d expected 1 1 0", free_count, in_ready, out_valid); else pass_cnt++;
        tick();
        total_cnt++; if (out_pdest !== 6'd5 || out_old_pdest !== 6'd34 || out_has_dest !== 1'b1 || free_count !== 7'd0) $display("FAIL exh_realloc: got pdest %0d old %0d has %0d free %0d expected 5 34 1 0", out_pdest, out_old_pdest, out_has_dest, free_count); else pass_cnt++;
        drive(0, 0, 0, 0, 0, '0);
        tick();
    endtask

    task automatic test_midstream_reset();
        drive(1, 1, 2, 5, 1, P1);
        tick();
        drive(1, 5, 5, 6, 1, P2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, '0);
        total_cnt++; if (out_valid !== 1'b0 || free_count !== 7'd32 || out_pdest !== 6'd0 || out_psrc1 !== 6'd0) $display("FAIL mid_reset: got valid %0d free %0d pdest %0d expected 0 32 0", out_valid, free_count, out_pdest); else pass_cnt++;
        drive(1, 5, 0, 9, 1, P3);
        tick();
        total_cnt++; if (out_psrc1 !== 6'd5 || out_pdest !== 6'd32 || out_old_pdest !== 6'd9 || free_count !== 7'd31) $display("FAIL mid_map: got src %0d pdest %0d old %0d free %0d expected 5 32 9 31", out_psrc1, out_pdest, out_old_pdest, free_count); else pass_cnt++;
        drive(0, 0, 0, 0, 0, '0);
        commit(1, 6'd0);
        tick();
        commit(0, '0);
        total_cnt++; if (free_count !== 7'd31 || fl_overflow !== 1'b0) $display("FAIL tag0_commit: got free %0d ovf %0d expected 31 0", free_count, fl_overflow); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1, 0, 0, 10, 1, P1);
        commit(1, 6'd45);
        tick();
        drive(0, 0, 0, 0, 0, '0);
        total_cnt++; if (out_pdest !== 6'd32 || free_count !== 7'd32 || fl_overflow !== 1'b0) $display("FAIL full_pushpop: got pdest %0d free %0d ovf %0d expected 32 32 0", out_pdest, free_count, fl_overflow); else pass_cnt++;
        commit(1, 6'd46);
        tick();
        commit(0, '0);
        total_cnt++; if (fl_overflow !== 1'b1 || free_count !== 7'd32) $display("FAIL overflow: got ovf %0d free %0d expected 1 32", fl_overflow, free_count); else pass_cnt++;
        tick();
        total_cnt++; if (fl_overflow !== 1'b1) $display("FAIL ovf_sticky: got %0d expected 1", fl_overflow); else pass_cnt++;
        do_reset();
        total_cnt++; if (fl_overflow !== 1'b0) $display("FAIL ovf_clear: got %0d expected 0", fl_overflow); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rename_dep();
        test_no_alloc();
        test_stall();
        test_exhaust();
        test_midstream_reset();
        test_overflow();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage directly downstream of the ID/EX pipeline register.
- Consumes the decoded instruction fields that register holds (source/destination architectural registers, regWrite, opcode/funct/imm/control sideband).
- Maps architectural registers to physical tags through a register alias table (RAT) and a free list.
- Presents renamed instructions to dispatch through a one-entry valid/ready output register. Retirement returns stale physical tags through a commit port.

Parameters:
- PHYS_REGS, 64, number of physical registers; must be greater than 32 and a power of two.
- PTAG_W, 6, physical tag width, equal to clog2(PHYS_REGS).
- PAYLOAD_W, 101, width of the pass-through sideband bundle. Layout is defined in rename_pkg.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_src1  in  5  architectural rs1
- in_src2  in  5  architectural rs2
- in_dest  in  5  architectural rd
- in_regwrite  in  1  instruction writes rd
- in_payload  in  PAYLOAD_W  PC, opcode, funct3, funct7, imm, lwSw, memRead, memWrite, memToReg, hasImm, storeSize
- out_valid  out  1  renamed instruction valid
- out_ready  in  1  dispatch accepts
- out_psrc1  out  PTAG_W  physical tag for rs1
- out_psrc2  out  PTAG_W  physical tag for rs2
- out_pdest  out  PTAG_W  newly allocated tag, or 0
- out_old_pdest  out  PTAG_W  previous mapping of rd, to be freed at commit
- out_has_dest  out  1  allocation happened
- out_payload  out  PAYLOAD_W  sideband, unmodified
- commit_valid  in  1  retiring instruction
- commit_has_dest  in  1  retiring instruction allocated
- commit_old_pdest  in  PTAG_W  tag to return to the free list
- free_count  out  PTAG_W+1  current free-list occupancy
- fl_overflow  out  1  sticky error: push attempted while free list full

Behaviour:
- Reset is synchronous, active-high, and applies in any state, including mid-stream.
  - RAT[i] = i for i = 0..31.
  - Free list holds tags 32..PHYS_REGS-1 in ascending order; free_count = PHYS_REGS-32.
  - out_valid = 0; all out_* data = 0; fl_overflow = 0.
- need_alloc = in_regwrite AND in_dest != 0.
- in_ready = (!out_valid OR out_ready) AND (!need_alloc OR free_count != 0).
  - Uses registered free_count only. A tag freed in cycle N is not allocatable until cycle N+1.
- Accept = in_valid AND in_ready. On accept, outputs load at the next edge (latency 1 cycle):
  - psrc1/psrc2 = current RAT[src].
  - old_pdest = RAT[dest].
  - If need_alloc: pop free-list head into pdest, RAT[dest] <= pdest, has_dest = 1.
  - Otherwise pdest = 0 and has_dest = 0; RAT and free list are untouched.
  - out_valid <= 1.
- No accept and out_ready = 1: out_valid <= 0.
- Stall (out_valid AND !out_ready): all out_* held bit-stable; RAT and free list unchanged.
- Sources read the RAT before the same-edge update. A consecutive dependent instruction sees the new mapping because at most one rename occurs per cycle.
- Tag 0 is hardwired for x0. It is never allocated and never pushed: commit of tag 0 is ignored.
- Commit: commit_valid AND commit_has_dest AND tag != 0 pushes commit_old_pdest at the tail.
  - Push and pop may occur in the same cycle. free_count changes by push minus pop.
- Push while free_count == PHYS_REGS-32 with no same-cycle pop: drop the push, set fl_overflow (cleared only by rst).
- Free list is a circular FIFO of depth PHYS_REGS-32; head and tail pointers wrap modulo the depth.

Decomposition:
- rename_pkg holds:
  - ARCH_REGS = 32.
  - PAYLOAD_W and payload field offsets/widths: PC 32, opcode 7, funct3 3, funct7 7, imm 32, lwSw 2, memRead/memWrite/memToReg/hasImm/storeSize 1 each.
  - PTAG_W derivation helper.
- Sub-module rename_free_list: circular FIFO with pop, push, count and overflow flag.
- RAT and output register stay in rename_stage.

Test Plan:
1. After rst, with PHYS_REGS=64: rename add x5,x1,x2 -> next cycle out_psrc1=1, out_psrc2=2, out_pdest=32, out_old_pdest=5, out_has_dest=1, free_count=31.
2. Next cycle, sub x6,x5,x5 -> out_psrc1=out_psrc2=32, out_pdest=33, out_old_pdest=6.
3. Instruction with regWrite=1, rd=x0, or a store with regWrite=0 -> out_pdest=0, out_has_dest=0, free_count unchanged.
4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0; outputs and free_count stable; the first instruction after release renames correctly.
5. 32 allocating instructions with no commits -> in_ready falls after the 32nd (free_count=0). Then commit_old_pdest=5 -> in_ready=1 on the following cycle; the next allocation gets pdest=5.
6. Assert rst mid-stream -> the next cycle shows out_valid=0, free_count=32, and x5 maps to tag 5. Separately, push a commit while the free list is full -> fl_overflow=1 and free_count unchanged.
